apb_master: RTL and testbench

- APB initiator that converts a simple valid/ready command interface into APB transfers. Drives PSEL/PEN/PWRITE/PADDR/PWDATA and samples PREADY/PRDATA/PSLVERR.
- Sits between a local controller or testbench driver and the team's 8-bit APB slave memory.
- Returns one response per command; includes a wait-state timeout so a hung slave cannot stall the bus.

---
 rtl/apb_pkg.sv | 30 +++
 rtl/apb_master.sv | 141 ++++++++++++++
 tb/tb_apb_master.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer phases, default bus widths, command/response records.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    // Transfer phases of an APB initiator
    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_e;

    // Command record at default widths, for slaves and bench agents
    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_req_t;

    // Response record at default widths
    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_master.sv
// APB initiator: one valid/ready command becomes one APB transfer and one registered response pulse.
// Latency: accept edge -> SETUP -> ACCESS (1 + wait states) -> RSP_VALID the cycle after PREADY; 3 cycles minimum.
// Backpressure: REQ_READY only in IDLE or on the ACCESS completion cycle; a wait-state timeout bounds a hung slave.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WRITE,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic [DATA_W-1:0] REQ_WDATA,
    output logic              RSP_VALID,
    output logic [DATA_W-1:0] RSP_RDATA,
    output logic              RSP_ERR,
    output logic              RSP_TIMEOUT,
    output logic              PSEL,
    output logic              PEN,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    input  logic [DATA_W-1:0] PRDATA
);

    localparam logic [1:0] ST_IDLE   = APB_IDLE;
    localparam logic [1:0] ST_SETUP  = APB_SETUP;
    localparam logic [1:0] ST_ACCESS = APB_ACCESS;

    // Counter must hold 0..TIMEOUT; keep one bit when the timeout is disabled
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [1:0]       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             accept;
    logic             complete;
    logic             timeout_hit;

    // Ready in IDLE, or on the completion cycle so the next command can chain without an IDLE gap
    assign REQ_READY   = (state == ST_IDLE) || ((state == ST_ACCESS) && PREADY);
    assign accept      = REQ_VALID && REQ_READY;
    assign complete    = (state == ST_ACCESS) && PREADY;
    assign timeout_hit = (state == ST_ACCESS) && !PREADY && (TIMEOUT != 0) && (wait_cnt == CNT_LAST);

    // Phase sequencing and APB request outputs; command fields latched only on accept
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= ST_IDLE;
            PSEL   <= 1'b0;
            PEN    <= 1'b0;
            PWRITE <= 1'b0;
            PADDR  <= '0;
            PWDATA <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        PWRITE <= REQ_WRITE;
                        PADDR  <= REQ_ADDR;
                        PWDATA <= REQ_WDATA;
                        PSEL   <= 1'b1;
                        PEN    <= 1'b0;
                        state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    PEN   <= 1'b1;
                    state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        if (accept) begin
                            // Chain straight into the next SETUP; PSEL stays asserted
                            PWRITE <= REQ_WRITE;
                            PADDR  <= REQ_ADDR;
                            PWDATA <= REQ_WDATA;
                            PEN    <= 1'b0;
                            state  <= ST_SETUP;
                        end else begin
                            PSEL  <= 1'b0;
                            PEN   <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end else if (timeout_hit) begin
                        PSEL  <= 1'b0;
                        PEN   <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    PSEL  <= 1'b0;
                    PEN   <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Wait-state counter: cleared in SETUP, counts stalled ACCESS cycles, saturates instead of wrapping
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wait_cnt <= '0;
        end else if (state == ST_SETUP) begin
            wait_cnt <= '0;
        end else if ((state == ST_ACCESS) && !PREADY && !timeout_hit && (wait_cnt != CNT_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Response pulse; data/status fields hold until the next response
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RSP_VALID   <= 1'b0;
            RSP_RDATA   <= '0;
            RSP_ERR     <= 1'b0;
            RSP_TIMEOUT <= 1'b0;
        end else begin
            RSP_VALID <= 1'b0;
            if (complete) begin
                RSP_VALID   <= 1'b1;
                RSP_RDATA   <= PWRITE ? '0 : PRDATA;
                RSP_ERR     <= PSLVERR;
                RSP_TIMEOUT <= 1'b0;
            end else if (timeout_hit) begin
                RSP_VALID   <= 1'b1;
                RSP_RDATA   <= '0;
                RSP_ERR     <= 1'b1;
                RSP_TIMEOUT <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: memory slave with per-transfer wait/error, reference model, response scoreboard.
// Latency: expected response latency derived per command from its wait states.
// Backpressure: commands are held until REQ_READY; slave stalls are randomized.
module tb_apb_master;
    import apb_pkg::*;

    localparam int TO = 4;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       REQ_VALID = 1'b0;
    logic       REQ_WRITE = 1'b0;
    logic [7:0] REQ_ADDR = '0;
    logic [7:0] REQ_WDATA = '0;
    logic       REQ_READY;
    logic       RSP_VALID;
    logic [7:0] RSP_RDATA;
    logic       RSP_ERR;
    logic       RSP_TIMEOUT;
    logic       PSEL;
    logic       PEN;
    logic       PWRITE;
    logic [7:0] PADDR;
    logic [7:0] PWDATA;
    logic       PREADY;
    logic       PSLVERR;
    logic [7:0] PRDATA;

    apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT),
        .PSEL(PSEL), .PEN(PEN), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", nm, act, req);
    endtask

    // ---------------- slave: memory with per-transfer wait states and error flag
    logic [7:0] init_mem [256];
    logic [7:0] mem [256];
    bit         mem_ready = 1'b0;
    int         cfg_wait_q[$];
    bit         cfg_err_q[$];
    int         cur_wait = 0;
    bit         cur_err = 1'b0;
    int         acc_cnt = 0;
    logic [7:0] junk = '0;
    logic       junk_b = 1'b0;

    assign PREADY  = PSEL && PEN && (acc_cnt == cur_wait);
    assign PSLVERR = PREADY ? cur_err : junk_b;
    assign PRDATA  = PREADY ? mem[PADDR] : junk;

    always @(posedge CLK) begin
        junk   <= 8'($urandom);
        junk_b <= 1'($urandom);
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_mem[i];
            mem_ready <= 1'b1;
        end else if (PSEL && !PEN) begin
            if (cfg_wait_q.size() > 0) begin
                cur_wait <= cfg_wait_q.pop_front();
                cur_err  <= cfg_err_q.pop_front();
            end
            acc_cnt <= 0;
        end else if (PSEL && PEN) begin
            if (PREADY) begin
                if (PWRITE && !cur_err) mem[PADDR] <= PWDATA;
                acc_cnt <= 0;
            end else begin
                acc_cnt <= acc_cnt + 1;
            end
        end else begin
            acc_cnt <= 0;
        end
    end

    // ---------------- reference model and scoreboard
    typedef struct {
        apb_rsp_t rsp;
        int       acc;
        int       lat;
    } exp_t;

    logic [7:0] ref_mem [256];
    exp_t       exp_q[$];

    // Expected outcome from the protocol rules: slaves stalling TO or more cycles are aborted
    function automatic exp_t model(input logic w, input logic [7:0] a, input logic [7:0] d,
                                   input int wt, input bit er);
        exp_t e;
        e.acc = cyc;
        if (wt >= TO) begin
            e.rsp.rdata   = 8'h00;
            e.rsp.err     = 1'b1;
            e.rsp.timeout = 1'b1;
            e.lat         = 2 + TO;
        end else begin
            e.rsp.rdata   = w ? 8'h00 : ref_mem[a];
            e.rsp.err     = er;
            e.rsp.timeout = 1'b0;
            e.lat         = 3 + wt;
            if (w && !er) ref_mem[a] = d;
        end
        return e;
    endfunction

    // Present a command, wait for acceptance, return on the negedge after the accepting edge
    task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d,
                         input int wt, input bit er, input bit hold);
        int n;
        REQ_VALID = 1'b1;
        REQ_WRITE = w;
        REQ_ADDR  = a;
        REQ_WDATA = d;
        n = 0;
        while (!REQ_READY && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!REQ_READY) begin
            n_total++;
            $display("FAIL req_accept: REQ_READY=%0b after 100 cycles, required 1", REQ_READY);
        end else begin
            exp_q.push_back(model(w, a, d, wt, er));
            cfg_wait_q.push_back(wt);
            cfg_err_q.push_back(er);
        end
        @(negedge CLK);
        if (!hold) REQ_VALID = 1'b0;
    endtask

    // Count PSEL/PEN cycles from SETUP until RSP_VALID appears
    task automatic wait_rsp(output int ps, output int pe);
        int n;
        n  = 0;
        ps = int'(PSEL);
        pe = int'(PEN);
        @(negedge CLK);
        while (!RSP_VALID && n < 40) begin
            ps += int'(PSEL);
            pe += int'(PEN);
            @(negedge CLK);
            n++;
        end
        if (!RSP_VALID) begin
            n_total++;
            $display("FAIL rsp_wait: RSP_VALID=0 after 40 cycles, required 1");
        end
    endtask

    // Response monitor: pops the scoreboard whenever the DUT presents a response
    bit prev_rsp = 1'b0;
    always @(negedge CLK) begin : mon
        exp_t e;
        if (!RST_N) begin
            prev_rsp = 1'b0;
        end else begin
            if (RSP_VALID) begin
                chk("rsp_single_pulse", 32'(prev_rsp), 32'd0);
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL rsp_unexpected: got RSP_VALID=1 with nothing outstanding, required 0");
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", 32'(RSP_RDATA), 32'(e.rsp.rdata));
                    chk("rsp_err", 32'(RSP_ERR), 32'(e.rsp.err));
                    chk("rsp_timeout", 32'(RSP_TIMEOUT), 32'(e.rsp.timeout));
                    chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
                end
            end
            prev_rsp = RSP_VALID;
        end
    end

    // Bus protocol monitor: one-cycle SETUP, stable request fields, no ready while stalled
    bit          prev_setup = 1'b0;
    logic [16:0] snap = '0;
    bit          in_b2b = 1'b0;
    int          b2b_gaps = 0;
    always @(negedge CLK) begin
        if (!RST_N) begin
            prev_setup = 1'b0;
        end else begin
            if (prev_setup) chk("setup_one_cycle", 32'(PEN), 32'd1);
            if (PEN) chk("pen_needs_psel", 32'(PSEL), 32'd1);
            if (PSEL && !PEN) snap = {PWRITE, PADDR, PWDATA};
            if (PSEL && PEN) begin
                chk("apb_stable", 32'({PWRITE, PADDR, PWDATA}), 32'(snap));
                if (!PREADY) chk("ready_low_in_wait", 32'(REQ_READY), 32'd0);
            end
            if (in_b2b && !PSEL) b2b_gaps++;
            prev_setup = PSEL && !PEN;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int ps, pe, n;
        logic w;
        logic [7:0] a, d;
        int wt;
        bit er, hold;

        for (int i = 0; i < 256; i++) begin
            init_mem[i] = 8'($urandom);
            ref_mem[i]  = init_mem[i];
        end

        // Reset state while held, then after release
        @(negedge CLK);
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_pen", 32'(PEN), 32'd0);
        chk("rst_apb_fields", 32'({PWRITE, PADDR, PWDATA}), 32'd0);
        chk("rst_rsp", 32'({RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT}), 32'd0);
        #2 RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        chk("idle_ready", 32'(REQ_READY), 32'd1);
        chk("idle_psel", 32'(PSEL), 32'd0);

        // Write then read with one wait state
        issue(1'b1, 8'd3, 8'hA5, 1, 1'b0, 1'b0);
        wait_rsp(ps, pe);
        chk("wr_psel_cycles", 32'(ps), 32'd3);
        chk("wr_pen_cycles", 32'(pe), 32'd2);
        issue(1'b0, 8'd3, 8'h00, 1, 1'b0, 1'b0);
        wait_rsp(ps, pe);
        chk("rd_data_a5", 32'(RSP_RDATA), 32'hA5);
        chk("rd_psel_cycles", 32'(ps), 32'd3);
        chk("rd_pen_cycles", 32'(pe), 32'd2);

        // Back-to-back writes with REQ_VALID held
        b2b_gaps = 0;
        issue(1'b1, 8'd0, 8'h11, 1, 1'b0, 1'b1);
        in_b2b = 1'b1;
        issue(1'b1, 8'd1, 8'h22, 1, 1'b0, 1'b1);
        issue(1'b1, 8'd2, 8'h33, 1, 1'b0, 1'b0);
        in_b2b = 1'b0;
        chk("b2b_psel_gaps", 32'(b2b_gaps), 32'd0);
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, 8'(i), 8'h00, 0, 1'b0, 1'b0);
            wait_rsp(ps, pe);
        end

        // Slave error after two wait states
        issue(1'b0, 8'd5, 8'h00, 2, 1'b1, 1'b0);
        wait_rsp(ps, pe);
        chk("err_flag", 32'(RSP_ERR), 32'd1);
        chk("err_idle_psel", 32'(PSEL), 32'd0);
        chk("err_idle_ready", 32'(REQ_READY), 32'd1);

        // Timeout: slave never ready
        issue(1'b0, 8'd7, 8'h00, 255, 1'b0, 1'b0);
        wait_rsp(ps, pe);
        chk("to_pen_cycles", 32'(pe), 32'(TO));
        chk("to_psel_low", 32'(PSEL), 32'd0);
        chk("to_pen_low", 32'(PEN), 32'd0);
        chk("to_ready_after", 32'(REQ_READY), 32'd1);

        // Asynchronous reset in the middle of ACCESS
        issue(1'b0, 8'd9, 8'h00, 255, 1'b0, 1'b0);
        repeat (2) @(negedge CLK);
        #1 RST_N = 1'b0;
        #1;
        chk("arst_psel", 32'(PSEL), 32'd0);
        chk("arst_pen", 32'(PEN), 32'd0);
        chk("arst_rsp_valid", 32'(RSP_VALID), 32'd0);
        exp_q.delete();
        cfg_wait_q.delete();
        cfg_err_q.delete();
        @(negedge CLK);
        #1 RST_N = 1'b1;
        repeat (8) @(negedge CLK);
        issue(1'b0, 8'd0, 8'h00, 1, 1'b0, 1'b0);
        wait_rsp(ps, pe);
        chk("post_rst_rd", 32'(RSP_RDATA), 32'h11);

        // Randomized traffic with random stalls, errors, occasional timeouts and chaining
        for (int k = 0; k < 40; k++) begin
            w    = 1'($urandom);
            a    = 8'($urandom_range(0, 15));
            d    = 8'($urandom);
            wt   = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
            er   = ($urandom_range(0, 7) == 0);
            hold = ($urandom_range(0, 2) == 0);
            issue(w, a, d, wt, er, hold);
            if (!hold) repeat ($urandom_range(0, 2)) @(negedge CLK);
        end
        REQ_VALID = 1'b0;

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("drain_outstanding", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
